// File: rtl/pulse_period_meter_pkg.sv
// Shared constants and FSM encoding for the tick period meter.
// The tick generator imports the same defaults so both ends agree.
package pulse_period_meter_pkg;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_TIMEOUT = 1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MEAS = 2'd1,
      ST_TOUT = 2'd2
   } meter_state_e;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector for a clk-synchronous strobe.
// The edge output is combinational from pulse_in.
module pulse_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic pulse_in,
   output logic pulse_edge
);

   logic pulse_d;

   always_ff @(posedge clk) begin
      if (rst) pulse_d <= 1'b0;
      else     pulse_d <= pulse_in;
   end

   assign pulse_edge = pulse_in & ~pulse_d;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between rising edges of a strobe.
// Reports periods over valid/ready and tracks min/max, lost ticks and unread results.
module pulse_period_meter
   import pulse_period_meter_pkg::*;
#(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pulse_in,
   input  logic             clr,
   input  logic             period_ready,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic [CNT_W-1:0] period_min,
   output logic [CNT_W-1:0] period_max,
   output logic             timeout,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   meter_state_e     state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout_nxt;
   logic             capture;
   logic             pulse_edge;

   pulse_edge_detect u_edge (
      .clk        (clk),
      .rst        (rst),
      .pulse_in   (pulse_in),
      .pulse_edge (pulse_edge)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         timeout <= timeout_nxt;
      end
   end

   // An edge takes priority over the timeout check, so a period of exactly TIMEOUT is captured.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      timeout_nxt = timeout;
      capture     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pulse_edge) begin
               cnt_nxt   = ONE;
               state_nxt = ST_MEAS;
            end
         end
         ST_MEAS: begin
            if (pulse_edge) begin
               capture = 1'b1;
               cnt_nxt = ONE;
            end else if (cnt == TMO) begin
               state_nxt   = ST_TOUT;
               timeout_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + ONE;
            end
         end
         ST_TOUT: begin
            if (pulse_edge) begin
               cnt_nxt     = ONE;
               timeout_nxt = 1'b0;
               state_nxt   = ST_MEAS;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_out   <= '0;
         period_valid <= 1'b0;
      end else if (capture) begin
         period_out   <= cnt;
         period_valid <= 1'b1;
      end else if (period_ready) begin
         period_valid <= 1'b0;
      end
   end

   // clr restarts tracking; a capture in the same cycle seeds min/max with the new period.
   always_ff @(posedge clk) begin
      if (rst) begin
         period_min <= '1;
         period_max <= '0;
         overrun    <= 1'b0;
      end else begin
         if (clr) begin
            period_min <= capture ? cnt : '1;
            period_max <= capture ? cnt : '0;
            overrun    <= capture & period_valid & ~period_ready;
         end else if (capture) begin
            if (cnt < period_min) period_min <= cnt;
            if (cnt > period_max) period_max <= cnt;
            if (period_valid && !period_ready) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter with TIMEOUT = 20.
// Edges are scheduled relative to the previous edge cycle so gaps are exact.
module tb_pulse_period_meter;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 20;

   logic             clk = 1'b0;
   logic             rst, pulse_in, clr, period_ready;
   logic [CNT_W-1:0] period_out, period_min, period_max;
   logic             period_valid, timeout, overrun;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int last   = 0;

   pulse_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .rst          (rst),
      .pulse_in     (pulse_in),
      .clr          (clr),
      .period_ready (period_ready),
      .period_out   (period_out),
      .period_valid (period_valid),
      .period_min   (period_min),
      .period_max   (period_max),
      .timeout      (timeout),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int gap);
      while (cyc < last + gap) step();
   endtask

   // pulse_in is high for the current cycle, which becomes the new edge cycle
   task automatic pulse();
      pulse_in = 1'b1;
      last     = cyc;
      step();
      pulse_in = 1'b0;
   endtask

   task automatic tick_at(input int gap);
      wait_to(gap);
      pulse();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".out"},   32'(period_out), 32'h0);
      chk({tag, ".valid"}, 32'(period_valid), 32'h0);
      chk({tag, ".min"},   32'(period_min), 32'hffff);
      chk({tag, ".max"},   32'(period_max), 32'h0);
      chk({tag, ".tmo"},   32'(timeout), 32'h0);
      chk({tag, ".ovr"},   32'(overrun), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pulse_in = 1'b0; clr = 1'b0; period_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      chk_reset("rst");

      // ticks every 10 cycles, ready held high
      pulse();
      chk("first.valid", 32'(period_valid), 32'h0);
      tick_at(10);
      chk("p10a.out", 32'(period_out), 32'd10);
      chk("p10a.valid", 32'(period_valid), 32'h1);
      tick_at(10);
      chk("p10b.out", 32'(period_out), 32'd10);
      chk("p10b.min", 32'(period_min), 32'd10);
      chk("p10b.max", 32'(period_max), 32'd10);
      step();
      chk("p10b.drain", 32'(period_valid), 32'h0);

      // silence: timeout rises TIMEOUT+1 cycles after the edge
      wait_to(20);
      chk("tmo.before", 32'(timeout), 32'h0);
      step();
      chk("tmo.rise", 32'(timeout), 32'h1);
      tick_at(26);
      chk("tmo.clear", 32'(timeout), 32'h0);
      chk("tmo.nocap", 32'(period_valid), 32'h0);
      tick_at(7);
      chk("after_tmo.out", 32'(period_out), 32'd7);
      chk("after_tmo.min", 32'(period_min), 32'd7);
      chk("after_tmo.max", 32'(period_max), 32'd10);
      step();

      // unread results: 5 then 7 with ready low
      period_ready = 1'b0;
      tick_at(5);
      chk("ovr5.out", 32'(period_out), 32'd5);
      chk("ovr5.ovr", 32'(overrun), 32'h0);
      tick_at(7);
      chk("ovr7.out", 32'(period_out), 32'd7);
      chk("ovr7.ovr", 32'(overrun), 32'h1);
      chk("ovr7.min", 32'(period_min), 32'd5);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr.ovr", 32'(overrun), 32'h0);
      chk("clr.valid", 32'(period_valid), 32'h1);
      chk("clr.out", 32'(period_out), 32'd7);
      chk("clr.min", 32'(period_min), 32'hffff);
      chk("clr.max", 32'(period_max), 32'h0);
      period_ready = 1'b1;
      step();
      chk("ready.drain", 32'(period_valid), 32'h0);

      // boundary: exactly TIMEOUT captures, TIMEOUT+1 does not
      tick_at(20);
      chk("b20.out", 32'(period_out), 32'd20);
      chk("b20.tmo", 32'(timeout), 32'h0);
      chk("b20.min", 32'(period_min), 32'd20);
      chk("b20.max", 32'(period_max), 32'd20);
      wait_to(21);
      chk("b21.tmo", 32'(timeout), 32'h1);
      pulse();
      chk("b21.nocap", 32'(period_valid), 32'h0);
      chk("b21.out", 32'(period_out), 32'd20);
      chk("b21.tmo_clr", 32'(timeout), 32'h0);

      // level held 50 cycles counts once, then times out
      wait_to(5);
      pulse_in = 1'b1;
      last = cyc;
      step();
      chk("hold.out", 32'(period_out), 32'd5);
      chk("hold.valid", 32'(period_valid), 32'h1);
      wait_to(20);
      chk("hold.tmo0", 32'(timeout), 32'h0);
      wait_to(50);
      chk("hold.tmo1", 32'(timeout), 32'h1);
      chk("hold.once", 32'(period_out), 32'd5);
      pulse_in = 1'b0;
      step();
      pulse();
      chk("hold.rearm", 32'(timeout), 32'h0);

      // reset 4 cycles into an interval abandons it
      wait_to(4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset("midrst");
      tick_at(10);
      chk("midrst.first", 32'(period_valid), 32'h0);
      tick_at(10);
      chk("midrst.out", 32'(period_out), 32'd10);
      chk("midrst.valid", 32'(period_valid), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pulse_period_meter.md
# pulse_period_meter

Measures the number of `clk` cycles between successive rising edges of a single-bit strobe. The strobe is typically the one-cycle tick from the clock-divider/tick generator in the MIPS datapath. The block is the receiving end of that tick interface. It reports each measured period through a valid/ready handshake, tracks minimum and maximum periods, and flags lost ticks (timeout) and unread results (overrun).

## Interface
Parameters:
- `CNT_W`, 16: width of the period counter and all period outputs.
- `TIMEOUT`, 1000: cycle count after the last edge at which the tick is declared lost. Legal range is 2 .. 2^CNT_W−1.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pulse_in`, in, 1: strobe, synchronous to `clk`. It may be a one-cycle pulse or a level; only rising edges count.
- `clr`, in, 1: synchronous clear of `period_min`, `period_max` and `overrun`.
- `period_ready`, in, 1: consumer accepts `period_out`.
- `period_out`, out, `CNT_W`: last captured period in cycles.
- `period_valid`, out, 1: `period_out` holds an unread result.
- `period_min`, out, `CNT_W`: smallest period since reset or `clr`.
- `period_max`, out, `CNT_W`: largest period since reset or `clr`.
- `timeout`, out, 1: no edge seen for `TIMEOUT` cycles.
- `overrun`, out, 1: sticky; a result was overwritten before it was read.

## Operation
- Edge detect: `edge = pulse_in & ~pulse_d`, where `pulse_d` is a registered copy of `pulse_in` (reset value 0).
- FSM has three states:
  - IDLE (reset state): on `edge`, set `cnt` to 1 and go to MEAS. No capture is made on the first edge.
  - MEAS, on `edge`: capture `cnt` as the period, set `cnt` to 1, stay in MEAS.
  - MEAS, no edge and `cnt == TIMEOUT`: go to TOUT and set `timeout` to 1. No capture is made.
  - MEAS, otherwise: `cnt` increments by 1.
  - TOUT: `cnt` holds. On `edge`, set `cnt` to 1, clear `timeout`, go to MEAS. The lost interval is never reported as a period.
- Capture:
  - Loads `period_out` and sets `period_valid`.
  - Updates `period_min = min(period_min, p)` and `period_max = max(period_max, p)`.
- Handshake:
  - `period_valid` stays high until a cycle where `period_ready` is 1. It then clears on the next edge of `clk`, unless a capture happens in that same cycle.
  - `period_out` is stable while `period_valid` is high and no capture occurs.
- Capture while `period_valid && !period_ready`: the new value overwrites `period_out` (latest wins) and `overrun` is set.
- Capture while `period_valid && period_ready`: the new value is loaded, `period_valid` stays 1, and there is no overrun.
- `clr`:
  - Loads `period_min` with all ones and `period_max` with 0, and clears `overrun`.
  - Has no effect on the FSM, `cnt`, `period_out` or `period_valid`.
  - `clr` together with a capture: min and max load the new value `p`; `overrun` takes that cycle's capture result.
- `edge` in the same cycle as `cnt == TIMEOUT`: the edge wins and period `TIMEOUT` is captured.
- Arithmetic is unsigned. `cnt` never exceeds `TIMEOUT`, so it cannot wrap.

## Timing
- Values after reset:
  - `period_out` = 0, `period_valid` = 0, `timeout` = 0, `overrun` = 0.
  - `period_min` = all ones, `period_max` = 0.
  - `cnt` = 0, state = IDLE, `pulse_d` = 0.
- Period definition: edges in cycles t0 and t1 give a period of t1 − t0.
- Latency: `period_valid`, `period_out`, `period_min` and `period_max` update on the clock edge that ends the cycle in which `pulse_in` rises. `edge` is combinational from `pulse_in`.
- `timeout` rises TIMEOUT+1 cycles after the last edge cycle.
- `rst` asserted mid-measurement abandons the interval with no capture. The next edge after `rst` is treated as a first edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- A shared package/include holds:
  - the FSM state encodings (IDLE, MEAS, TOUT);
  - the default values of `CNT_W` and `TIMEOUT`, so the tick generator and this meter agree on the same constants.
- One sub-module: `pulse_edge_detect`, with inputs `clk`, `rst`, `pulse_in` and output `edge`, containing the `pulse_d` register.
- The FSM, counter, handshake and min/max tracking live in the top-level block.

## Test plan
- One-cycle ticks every 10 cycles with `period_ready` = 1 → `period_out` = 10 on every capture, no capture for the first tick, `period_min` = `period_max` = 10.
- `TIMEOUT` = 20, one tick then silence → `timeout` rises 21 cycles after the edge. A later tick clears it with no capture. The tick after that gives the correct period.
- `period_ready` = 0, ticks spaced 5 then 7 cycles apart → `period_out` = 7, `overrun` = 1. Pulsing `clr` clears `overrun` but `period_valid` stays 1. `period_ready` = 1 then clears `period_valid`.
- `TIMEOUT` = 20, edges exactly 20 cycles apart → period 20 is captured and `timeout` stays 0. With edges 21 cycles apart → `timeout` = 1 and there is no capture.
- `pulse_in` held high for 50 cycles → only one edge is counted, and `timeout` follows if the hold exceeds `TIMEOUT`.
- `rst` asserted for one cycle 4 cycles into a 10-cycle interval → all outputs return to their reset values, and the first capture comes only after two further edges.
